// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined CLA adder: slice width, op encoding,
// and the stage-count derivation.
package cla_pipe_adder_pkg;

   localparam int CLA_SLICE_W = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Number of pipeline stages; the top rejects widths that do not divide evenly.
   function automatic int cla_nstg(input int width, input int slices_per_stg);
      return width / (CLA_SLICE_W * slices_per_stg);
   endfunction

   function automatic bit cla_width_ok(input int width, input int slices_per_stg);
      return (slices_per_stg >= 1) && (width >= CLA_SLICE_W * slices_per_stg) &&
             ((width % (CLA_SLICE_W * slices_per_stg)) == 0);
   endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice; also exposes the carry into its top bit so
// the last stage can derive signed overflow.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c_msb
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                 (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s     = p ^ c[3:0];
   assign co    = c[4];
   assign c_msb = c[3];

endmodule

// File: rtl/cla_pipe_stage.sv
// One pipeline stage worth of adder: SLICES cla4 blocks with the carry
// rippling slice-to-slice.
module cla_pipe_stage
   import cla_pipe_adder_pkg::*;
#(
   parameter int SLICES = 2
) (
   input  logic [SLICES*CLA_SLICE_W-1:0] a,
   input  logic [SLICES*CLA_SLICE_W-1:0] b,
   input  logic                          ci,
   output logic [SLICES*CLA_SLICE_W-1:0] s,
   output logic                          co,
   output logic                          c_top
);

   for (genvar i = 0; i < SLICES; i++) begin : g_slice
      logic cin;
      logic cout;
      logic cmsb;

      // Per-slice carry nets keep the ripple free of a shared vector.
      if (i == 0) begin : g_first
         assign cin = ci;
      end else begin : g_next
         assign cin = g_slice[i-1].cout;
      end

      cla4 u_cla4 (
         .a     (a[i*CLA_SLICE_W +: CLA_SLICE_W]),
         .b     (b[i*CLA_SLICE_W +: CLA_SLICE_W]),
         .ci    (cin),
         .s     (s[i*CLA_SLICE_W +: CLA_SLICE_W]),
         .co    (cout),
         .c_msb (cmsb)
      );

      if (i == SLICES-1) begin : g_top
         assign co    = cout;
         assign c_top = cmsb;
      end else begin : g_mid
         logic unused_cmsb;
         assign unused_cmsb = cmsb;
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control;
// stage k adds its slice group using the carry registered by stage k-1.
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int SLICES_PER_STG = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int SW   = CLA_SLICE_W * SLICES_PER_STG;
   localparam int NSTG = cla_nstg(WIDTH, SLICES_PER_STG);

   if (!cla_width_ok(WIDTH, SLICES_PER_STG)) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*SLICES_PER_STG");
   end

   op_e              op;
   logic [WIDTH-1:0] b_ent;
   logic             c_ent;

   // Subtraction folds into an add at entry: a + ~b + 1.
   assign op    = op_e'(sub);
   assign b_ent = (op == OP_SUB) ? ~b : b;
   assign c_ent = (op == OP_SUB) ? 1'b1 : ci;

   logic [NSTG-1:0]            vld_pipe;
   logic [NSTG-1:0]            cy_q;
   logic [NSTG-1:0]            ctop_w;
   logic [NSTG:0]              ld;
   logic [NSTG-1:0][WIDTH-1:0] a_q;
   logic [NSTG-1:0][WIDTH-1:0] b_q;
   logic [NSTG-1:0][WIDTH-1:0] sum_q;

   // A stage may load when empty or when its content moves on this cycle.
   always_comb begin
      ld       = '0;
      ld[NSTG] = out_ready;
      for (int k = NSTG-1; k >= 0; k--) begin
         ld[k] = ~vld_pipe[k] | ld[k+1];
      end
   end

   assign in_ready = ld[0];

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] sum_in;
      logic [WIDTH-1:0] sum_d;
      logic             c_in;
      logic             v_in;
      logic             c_out;
      logic             c_top;
      logic [SW-1:0]    s_slice;
      logic             v_r;
      logic             cy_r;
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] sum_r;

      if (k == 0) begin : g_head
         assign a_in   = a;
         assign b_in   = b_ent;
         assign c_in   = c_ent;
         assign sum_in = '0;
         assign v_in   = in_valid;
      end else begin : g_body
         assign a_in   = a_q[k-1];
         assign b_in   = b_q[k-1];
         assign c_in   = cy_q[k-1];
         assign sum_in = sum_q[k-1];
         assign v_in   = vld_pipe[k-1];
      end

      cla_pipe_stage #(
         .SLICES (SLICES_PER_STG)
      ) u_stage (
         .a     (a_in[k*SW +: SW]),
         .b     (b_in[k*SW +: SW]),
         .ci    (c_in),
         .s     (s_slice),
         .co    (c_out),
         .c_top (c_top)
      );

      always_comb begin
         sum_d              = sum_in;
         sum_d[k*SW +: SW]  = s_slice;
      end

      // Data only moves with a valid op, so a drained last stage keeps its outputs.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_r   <= 1'b0;
            cy_r  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
         end else if (ld[k]) begin
            v_r <= v_in;
            if (v_in) begin
               cy_r  <= c_out;
               a_r   <= a_in;
               b_r   <= b_in;
               sum_r <= sum_d;
            end
         end
      end

      assign vld_pipe[k] = v_r;
      assign cy_q[k]     = cy_r;
      assign a_q[k]      = a_r;
      assign b_q[k]      = b_r;
      assign sum_q[k]    = sum_r;
      assign ctop_w[k]   = c_top;

      if (k == NSTG-1) begin : g_tail
         logic ovf_r;
         logic zero_r;

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_r  <= 1'b0;
               zero_r <= 1'b0;
            end else if (ld[k] && v_in) begin
               ovf_r  <= c_top ^ c_out;
               zero_r <= ~|sum_d;
            end
         end

         assign ovf  = ovf_r;
         assign zero = zero_r;
      end
   end

   assign out_valid = vld_pipe[NSTG-1];
   assign s         = sum_q[NSTG-1];
   assign co        = cy_q[NSTG-1];

   logic unused_tail;
   assign unused_tail = ^{a_q[NSTG-1], b_q[NSTG-1], ctop_w};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed + random bench for cla_pipe_adder: scoreboard of model results
// pushed on accept, popped and compared on each output transfer.
module tb_cla_pipe_adder;

   localparam int W    = 32;
   localparam int SPS  = 2;
   localparam int NSTG = W / (4 * SPS);

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         co;
   logic         ovf;
   logic         zero;

   always #5 clk = ~clk;

   cla_pipe_adder #(
      .WIDTH          (W),
      .SLICES_PER_STG (SPS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .ovf       (ovf),
      .zero      (zero)
   );

   int           n_vec = 0;
   int           n_err = 0;
   int           cyc   = 0;
   int           t0;
   bit           lat_chk;
   logic [W+2:0] exp_q[$];
   int           cyc_q[$];
   logic         acc;
   int           n;
   int           t;
   int           cnt;
   logic [W-1:0] prev_s;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: wide add of a + B' + c0, flags from operand/result signs.
   function automatic logic [W+2:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb0,
                                          input logic cc, input logic ss);
      logic [W-1:0] bb;
      logic [W-1:0] r;
      logic         c;
      logic         cout;
      bb = ss ? ~bb0 : bb0;
      c  = ss ? 1'b1 : cc;
      {cout, r} = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
      return {r, cout, (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]), r == '0};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         cyc_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("stale_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               chk("result", {s, co, ovf, zero}, exp_q.pop_front());
               t0 = cyc_q.pop_front();
               if (lat_chk) chk("latency", cyc - t0, NSTG);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, ci, sub));
            cyc_q.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic tsub);
      a        = ta;
      b        = tb;
      ci       = tci;
      sub      = tsub;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            step();
            return;
         end
      end
      chk("issue_timeout", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run1(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tci, input logic tsub, input logic [W-1:0] es,
                       input logic eco, input logic eovf, input logic ezero);
      issue(ta, tb, tci, tsub);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) step();
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_s"}, s, es);
      chk({tag, "_flags"}, {co, ovf, zero}, {eco, eovf, ezero});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_s", s, 0);
      chk("rst_flags", {co, ovf, zero}, 3'b000);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // First op: exact latency of NSTG cycles
      issue(32'h1, 32'h1, 1'b0, 1'b0);
      in_valid = 1'b0;
      repeat (NSTG-2) step();
      chk("lat_early", {63'd0, out_valid}, 64'd0);
      step();
      chk("first_valid", {63'd0, out_valid}, 64'd1);
      chk("first_s", s, 32'h2);
      chk("first_flags", {co, ovf, zero}, 3'b000);
      step();

      run1("carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      run1("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run1("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run1("sub_ci_ign", 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
      run1("sub_eq", 32'h9, 32'h9, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      run1("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run1("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Back-to-back at full rate
      for (int i = 0; i < 6; i++) issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'(i % 2));
      in_valid = 1'b0;
      drain();

      // Backpressure: consumer stalls cycles 2..7 while 8 ops stream in
      lat_chk  = 1'b0;
      n        = 0;
      t        = 0;
      a        = $urandom;
      b        = $urandom;
      ci       = 1'b1;
      sub      = 1'b0;
      in_valid = 1'b1;
      while (n < 8 && t < 100) begin
         if (t == 2) out_ready = 1'b0;
         if (t == 8) out_ready = 1'b1;
         if (t >= 4 && t <= 7) begin
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         end
         if (t >= 5 && t <= 7) chk("bp_hold_s", s, prev_s);
         prev_s = s;
         @(negedge clk) acc = in_ready;
         step();
         t++;
         if (acc) begin
            n++;
            a   = $urandom;
            b   = $urandom;
            ci  = 1'($urandom_range(0, 1));
            sub = 1'(n % 2);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_accepted", n, 8);
      drain();

      // Reset with three ops in flight
      lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) issue(32'h1234_0000 + i, 32'h0000_4321, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_s", s, 0);
      chk("mid_rst_flags", {co, ovf, zero}, 3'b000);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("mid_rst_no_stale", {63'd0, out_valid}, 64'd0);
      end

      // Random traffic with random consumer backpressure
      lat_chk  = 1'b0;
      cnt      = 0;
      a        = pick();
      b        = pick();
      ci       = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5000 && cnt < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk) acc = in_valid && in_ready;
         step();
         if (acc) begin
            cnt++;
            a   = pick();
            b   = pick();
            ci  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
         end
         in_valid = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rand_count", cnt, 400);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
